axi_mem_responder: RTL and testbench

- AXI3-style responder (slave) for the core's memory arbiter. Terminates the AW/W/B and AR/R channels that the core drives as initiator.
- Backed by a word-addressed on-chip array with programmable read latency and optional R backpressure tolerance.
- Used as the simulation and FPGA memory model behind the core's AXI ports.
- Read and write engines are independent FSMs sharing one storage array.

---
 rtl/axi_mem_responder.sv | 255 +++++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI3-style responder backed by a word-addressed on-chip array.
// Independent read and write engines share one storage array. Read data is
// registered, so a presented beat stays stable while stalled. A write that lands
// on the same edge as a read fetch is forwarded, so later beats see the new value.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module axi_mem_responder #(
    parameter int MEM_ADDR_WIDTH     = 16,
    parameter int READ_LATENCY       = 4,
    parameter int WRITE_RESP_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    // write address channel
    output logic                   AWREADY,
    input  logic                   AWVALID,
    input  logic [3:0]             AWID,
    input  logic [3:0]             AWLEN,
    input  logic [`ADDR_WIDTH-1:0] AWADDR,
    // write data channel
    output logic                   WREADY,
    input  logic                   WVALID,
    input  logic                   WLAST,
    input  logic [3:0]             WID,
    input  logic [`DATA_WIDTH-1:0] WDATA,
    // write response channel
    input  logic                   BREADY,
    output logic                   BVALID,
    output logic [3:0]             BID,
    // read address channel
    output logic                   ARREADY,
    input  logic                   ARVALID,
    input  logic [3:0]             ARID,
    input  logic [3:0]             ARLEN,
    input  logic [`ADDR_WIDTH-1:0] ARADDR,
    // read data channel
    input  logic                   RREADY,
    output logic                   RVALID,
    output logic                   RLAST,
    output logic [3:0]             RID,
    output logic [`DATA_WIDTH-1:0] RDATA
);

    localparam int         DEPTH       = 1 << MEM_ADDR_WIDTH;
    localparam logic [3:0] RD_LAT_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LAT_LOAD = 4'(WRITE_RESP_LATENCY - 1);

    typedef logic [MEM_ADDR_WIDTH-1:0] index_t;
    typedef logic [`DATA_WIDTH-1:0]    word_t;

    typedef enum logic [1:0] { R_IDLE, R_WAIT, R_BURST }        rd_state_t;
    typedef enum logic [1:0] { W_IDLE, W_DATA, W_WAIT, W_RESP } wr_state_t;

    // NOTE: the storage array is deliberately never reset; its contents survive rst and it can map to block RAM.
    word_t mem [DEPTH];

    // read engine
    rd_state_t  rd_state, rd_state_nxt;
    logic [3:0] rd_cnt, rd_len, rd_beat, rd_id;
    index_t     rd_idx, rd_load_idx;
    word_t      rd_data;
    logic       ar_fire, r_fire, rd_last, rd_load;

    // write engine
    wr_state_t  wr_state, wr_state_nxt;
    logic [3:0] wr_cnt, wr_len, wr_beat, wr_id;
    index_t     wr_idx;
    logic       aw_fire, w_fire, wr_last;

    // Address bits above the array index alias; WID is not used for matching.
    logic unused_ok;
    assign unused_ok = ^{WID, WLAST, AWADDR[`ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                         ARADDR[`ADDR_WIDTH-1:MEM_ADDR_WIDTH]};

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    assign rd_last = (rd_beat == rd_len);

    // Read FSM next-state logic and AR/R handshake strobes
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        rd_state_nxt = rd_state;
        ARREADY      = 1'b0;
        RVALID       = 1'b0;
        ar_fire      = 1'b0;
        r_fire       = 1'b0;
        case (rd_state)
            R_IDLE: begin
                ARREADY = 1'b1;
                if (ARVALID) begin
                    ar_fire      = 1'b1;
                    rd_state_nxt = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rd_cnt == 4'd0) rd_state_nxt = R_BURST;
            end
            R_BURST: begin
                RVALID = 1'b1;
                if (RREADY) begin
                    r_fire = 1'b1;
                    if (rd_last) rd_state_nxt = R_IDLE;
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // Read FSM state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) rd_state <= R_IDLE;
        else     rd_state <= rd_state_nxt;
    end

    // Read burst bookkeeping: latched ID/LEN, array index, beat count, latency counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt  <= 4'd0;
            rd_len  <= 4'd0;
            rd_beat <= 4'd0;
            rd_id   <= 4'd0;
            rd_idx  <= '0;
        end else begin
            if (ar_fire) begin
                rd_id   <= ARID;
                rd_len  <= ARLEN;
                rd_idx  <= ARADDR[MEM_ADDR_WIDTH-1:0];
                rd_beat <= 4'd0;
                rd_cnt  <= RD_LAT_LOAD;
            end else if (rd_state == R_WAIT && rd_cnt != 4'd0) begin
                rd_cnt <= rd_cnt - 4'd1;
            end
            if (r_fire) begin
                rd_idx  <= rd_idx + index_t'(1);
                rd_beat <= rd_beat + 4'd1;
            end
        end
    end

    // Fetch a beat when the burst starts and after each accepted non-final beat.
    assign rd_load     = (rd_state == R_WAIT && rd_cnt == 4'd0) || (r_fire && !rd_last);
    assign rd_load_idx = r_fire ? rd_idx + index_t'(1) : rd_idx;

    // Read data register, forwarding a write that hits the fetched word on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_load) begin
            if (w_fire && wr_idx == rd_load_idx) rd_data <= WDATA;
            else                                 rd_data <= mem[rd_load_idx];
        end
    end

    assign RLAST = (rd_state == R_BURST) && rd_last;
    assign RID   = rd_id;
    assign RDATA = rd_data;

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    assign wr_last = (wr_beat == wr_len);

    // Write FSM next-state logic and AW/W/B handshake strobes
    always_comb begin
        wr_state_nxt = wr_state;
        AWREADY      = 1'b0;
        WREADY       = 1'b0;
        BVALID       = 1'b0;
        aw_fire      = 1'b0;
        w_fire       = 1'b0;
        case (wr_state)
            W_IDLE: begin
                AWREADY = 1'b1;
                if (AWVALID) begin
                    aw_fire      = 1'b1;
                    wr_state_nxt = W_DATA;
                end
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    w_fire = 1'b1;
                    // AWLEN alone decides the final beat; WLAST is only cross-checked.
                    if (wr_last) wr_state_nxt = W_WAIT;
                end
            end
            W_WAIT: begin
                if (wr_cnt == 4'd0) wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) wr_state_nxt = W_IDLE;
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (rst) wr_state <= W_IDLE;
        else     wr_state <= wr_state_nxt;
    end

    // Write burst bookkeeping: latched ID/LEN, array index, beat count, response delay
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt  <= 4'd0;
            wr_len  <= 4'd0;
            wr_beat <= 4'd0;
            wr_id   <= 4'd0;
            wr_idx  <= '0;
        end else begin
            if (aw_fire) begin
                wr_id   <= AWID;
                wr_len  <= AWLEN;
                wr_idx  <= AWADDR[MEM_ADDR_WIDTH-1:0];
                wr_beat <= 4'd0;
            end else if (w_fire) begin
                wr_idx  <= wr_idx + index_t'(1);
                wr_beat <= wr_beat + 4'd1;
            end
            if (w_fire && wr_last) begin
                wr_cnt <= WR_LAT_LOAD;
            end else if (wr_state == W_WAIT && wr_cnt != 4'd0) begin
                wr_cnt <= wr_cnt - 4'd1;
            end
        end
    end

    // Array write port; a beat presented while rst is high is abandoned
    always_ff @(posedge clk) begin
        if (w_fire && !rst) mem[wr_idx] <= WDATA;
    end

    assign BID = wr_id;

`ifndef SYNTHESIS
    // Flag bursts whose WLAST marker disagrees with the final beat derived from AWLEN
    always @(posedge clk) begin
        if (!rst && w_fire) begin
            assert (WLAST == wr_last)
            else $error("axi_mem_responder: WLAST=%0b on beat %0d of AWLEN=%0d",
                        WLAST, wr_beat, wr_len);
        end
    end
`endif

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: directed plus randomized checks of axi_mem_responder
// against a word-array reference model held in the bench.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_axi_mem_responder;

    localparam int AW    = `ADDR_WIDTH;
    localparam int DW    = `DATA_WIDTH;
    localparam int MAW   = 16;
    localparam int RL    = 4;
    localparam int WRL   = 1;
    localparam int DEPTH = 1 << MAW;

    typedef logic [DW-1:0] burst_t [16];

    logic          clk = 1'b0;
    logic          rst;
    logic          AWREADY, AWVALID;
    logic [3:0]    AWID, AWLEN;
    logic [AW-1:0] AWADDR;
    logic          WREADY, WVALID, WLAST;
    logic [3:0]    WID;
    logic [DW-1:0] WDATA;
    logic          BREADY, BVALID;
    logic [3:0]    BID;
    logic          ARREADY, ARVALID;
    logic [3:0]    ARID, ARLEN;
    logic [AW-1:0] ARADDR;
    logic          RREADY, RVALID, RLAST;
    logic [3:0]    RID;
    logic [DW-1:0] RDATA;

    axi_mem_responder #(
        .MEM_ADDR_WIDTH(MAW), .READ_LATENCY(RL), .WRITE_RESP_LATENCY(WRL)
    ) dut (
        .clk(clk), .rst(rst),
        .AWREADY(AWREADY), .AWVALID(AWVALID), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
        .WREADY(WREADY), .WVALID(WVALID), .WLAST(WLAST), .WID(WID), .WDATA(WDATA),
        .BREADY(BREADY), .BVALID(BVALID), .BID(BID),
        .ARREADY(ARREADY), .ARVALID(ARVALID), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
        .RREADY(RREADY), .RVALID(RVALID), .RLAST(RLAST), .RID(RID), .RDATA(RDATA)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: word array indexed modulo the array depth.
    logic [DW-1:0] model_mem [int];

    function automatic int idx_of(input logic [AW-1:0] a, input int off);
        return (int'(a) + off) & (DEPTH - 1);
    endfunction

    function automatic logic [DW-1:0] model_rd(input int i);
        return model_mem.exists(i) ? model_mem[i] : '0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [3:0] len,
                            input logic [3:0] id, input burst_t data);
        int n;
        n = 0;
        while (!AWREADY && n < 40) begin tick(); n++; end
        check("aw_ready", AWREADY, 1);
        AWVALID = 1; AWADDR = addr; AWLEN = len; AWID = id;
        tick();
        AWVALID = 0;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!WREADY && n < 40) begin tick(); n++; end
            check("w_ready", WREADY, 1);
            WVALID = 1; WDATA = data[b]; WLAST = (b == int'(len)); WID = id;
            tick();
            model_mem[idx_of(addr, b)] = data[b];
        end
        WVALID = 0; WLAST = 0;
        check("w_ready_drop", WREADY, 0);
        n = 0;
        while (!BVALID && n < 40) begin tick(); n++; end
        check("b_latency", n, WRL);
        check("b_id", BID, id);
        BREADY = 1;
        tick();
        BREADY = 0;
        check("b_done", BVALID, 0);
    endtask

    // pat gives RREADY per cycle from the first RVALID cycle, repeating every plen cycles.
    task automatic do_read(input logic [AW-1:0] addr, input logic [3:0] len,
                           input logic [3:0] id, input logic [7:0] pat, input int plen);
        int n, b, step;
        n = 0;
        while (!ARREADY && n < 40) begin tick(); n++; end
        check("ar_ready", ARREADY, 1);
        ARVALID = 1; ARADDR = addr; ARLEN = len; ARID = id;
        tick();
        ARVALID = 0;
        check("ar_busy", ARREADY, 0);
        n = 0;
        while (!RVALID && n < 40) begin tick(); n++; end
        check("r_latency", n, RL);
        b = 0; step = 0;
        while (b <= int'(len) && step < 200) begin
            RREADY = pat[step % plen];
            check("r_valid", RVALID, 1);
            check("r_data", RDATA, model_rd(idx_of(addr, b)));
            check("r_last", RLAST, b == int'(len));
            check("r_id", RID, id);
            if (RREADY) b++;
            tick();
            step++;
        end
        RREADY = 0;
        check("r_beats", b, int'(len) + 1);
        check("r_end_valid", RVALID, 0);
        check("r_end_arready", ARREADY, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1, "watchdog");
    end

    initial begin
        burst_t        d;
        int            n;
        logic [DW-1:0] old0, old1, new0, new1;
        logic [AW-1:0] a;
        logic [3:0]    len;

        rst = 1; AWVALID = 0; AWID = 0; AWLEN = 0; AWADDR = 0;
        WVALID = 0; WLAST = 0; WID = 0; WDATA = 0; BREADY = 0;
        ARVALID = 0; ARID = 0; ARLEN = 0; ARADDR = 0; RREADY = 0;
        foreach (d[i]) d[i] = '0;

        // Reset values
        tick(); tick();
        check("rst_awready", AWREADY, 1);
        check("rst_arready", ARREADY, 1);
        check("rst_wready",  WREADY, 0);
        check("rst_bvalid",  BVALID, 0);
        check("rst_rvalid",  RVALID, 0);
        check("rst_rlast",   RLAST, 0);
        check("rst_bid",     BID, 0);
        check("rst_rid",     RID, 0);
        check("rst_rdata",   RDATA, 0);
        rst = 0;
        tick();

        // Preload 0x10..0x13 and read back as a 4-beat burst
        d[0] = 32'hA0; d[1] = 32'hA1; d[2] = 32'hA2; d[3] = 32'hA3;
        do_write(32'h10, 4'd3, 4'd1, d);
        do_read(32'h10, 4'd3, 4'd2, 8'hFF, 1);

        // Two-beat write then read back
        d[0] = 32'hDEAD; d[1] = 32'hBEEF;
        do_write(32'h20, 4'd1, 4'd5, d);
        do_read(32'h20, 4'd1, 4'd6, 8'hFF, 1);

        // RREADY pattern 1,0,0,1,1 on a 3-beat read
        do_read(32'h10, 4'd2, 4'd1, 8'b0001_1001, 5);

        // Index wrap at the top of the array, with aliased upper address bits
        d[0] = 32'h1234_5678; d[1] = 32'h9ABC_DEF0;
        do_write(32'h0001_FFFF, 4'd1, 4'd11, d);
        do_read(32'h0000_FFFF, 4'd1, 4'd12, 8'hFF, 1);
        do_read(32'h0003_0000, 4'd0, 4'd13, 8'hFF, 1);

        // Reset during beat 2 of a 4-beat read
        ARVALID = 1; ARADDR = 32'h10; ARLEN = 4'd3; ARID = 4'd3;
        tick();
        ARVALID = 0;
        n = 0;
        while (!RVALID && n < 40) begin tick(); n++; end
        check("rr_latency", n, RL);
        check("rr_beat0", RDATA, model_rd(32'h10));
        RREADY = 1;
        tick();
        check("rr_beat1_valid", RVALID, 1);
        check("rr_beat1", RDATA, model_rd(32'h11));
        rst = 1;
        tick();
        rst = 0; RREADY = 0;
        check("rr_rvalid", RVALID, 0);
        check("rr_arready", ARREADY, 1);
        check("rr_rlast", RLAST, 0);
        check("rr_rdata", RDATA, 0);
        do_read(32'h10, 4'd3, 4'd4, 8'hFF, 1);

        // AR and AW accepted in the same cycle
        ARVALID = 1; ARADDR = 32'h11; ARLEN = 4'd1; ARID = 4'd9;
        AWVALID = 1; AWADDR = 32'h40; AWLEN = 4'd1; AWID = 4'd10;
        check("cc_arready", ARREADY, 1);
        check("cc_awready", AWREADY, 1);
        tick();
        ARVALID = 0; AWVALID = 0;
        check("cc_ar_taken", ARREADY, 0);
        check("cc_aw_taken", AWREADY, 0);
        for (int b = 0; b < 2; b++) begin
            check("cc_wready", WREADY, 1);
            WVALID = 1; WDATA = $urandom(); WLAST = (b == 1);
            tick();
            model_mem[idx_of(32'h40, b)] = WDATA;
        end
        WVALID = 0; WLAST = 0;
        n = 0;
        while (!BVALID && n < 40) begin tick(); n++; end
        check("cc_bvalid", BVALID, 1);
        check("cc_bid", BID, 10);
        BREADY = 1;
        tick();
        BREADY = 0;
        n = 0;
        while (!RVALID && n < 40) begin tick(); n++; end
        for (int b = 0; b < 2; b++) begin
            RREADY = 1;
            check("cc_rvalid", RVALID, 1);
            check("cc_rdata", RDATA, model_rd(idx_of(32'h11, b)));
            check("cc_rid", RID, 9);
            check("cc_rlast", RLAST, b == 1);
            tick();
        end
        RREADY = 0;
        check("cc_r_done", RVALID, 0);

        // Write hitting the stalled beat keeps it stable; a write on the fetch edge is seen
        old0 = $urandom(); old1 = $urandom(); new0 = $urandom(); new1 = ~old1;
        d[0] = old0; d[1] = old1;
        do_write(32'h30, 4'd1, 4'd2, d);
        ARVALID = 1; ARADDR = 32'h30; ARLEN = 4'd1; ARID = 4'd7;
        tick();
        ARVALID = 0;
        n = 0;
        while (!RVALID && n < 40) begin tick(); n++; end
        check("hz_beat0", RDATA, old0);
        AWVALID = 1; AWADDR = 32'h30; AWLEN = 4'd1; AWID = 4'd8;
        tick();
        AWVALID = 0;
        check("hz_wready", WREADY, 1);
        WVALID = 1; WDATA = new0; WLAST = 0;
        tick();
        check("hz_hold_valid", RVALID, 1);
        check("hz_hold_data", RDATA, old0);
        WDATA = new1; WLAST = 1; RREADY = 1;
        tick();
        WVALID = 0; WLAST = 0; RREADY = 0;
        model_mem[32'h30] = new0;
        model_mem[32'h31] = new1;
        check("hz_beat1_valid", RVALID, 1);
        check("hz_beat1_data", RDATA, new1);
        check("hz_beat1_last", RLAST, 1);
        check("hz_rid", RID, 7);
        RREADY = 1;
        tick();
        RREADY = 0;
        check("hz_r_done", RVALID, 0);
        n = 0;
        while (!BVALID && n < 40) begin tick(); n++; end
        check("hz_bid", BID, 8);
        BREADY = 1;
        tick();
        BREADY = 0;
        do_read(32'h30, 4'd1, 4'd3, 8'hFF, 1);

        // Randomized traffic over region 0x100..0x15F
        for (int k = 0; k < 6; k++) begin
            foreach (d[i]) d[i] = $urandom();
            do_write(AW'(32'h100 + 16 * k), 4'd15, 4'(k), d);
        end
        for (int t = 0; t < 24; t++) begin
            a   = ($urandom() & 32'hFFFF_0000) | (32'h100 + $urandom_range(0, 80));
            len = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                foreach (d[i]) d[i] = $urandom();
                do_write(a, len, 4'($urandom()), d);
            end else begin
                do_read(a, len, 4'($urandom()), 8'($urandom()) | 8'h01, $urandom_range(1, 8));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
